// File: rtl/metronome_param_seven_seg.sv
// rtl/metronome_param_seven_seg.sv - bar metronome with BPM phase accumulator, accent/normal tones and beat digit
module metronome_param_seven_seg #(
  parameter int CLK_HZ     = 27000000,
  parameter int BEATS_MAX  = 8,
  parameter int ACCENT_DIV = 65014,
  parameter int NORMAL_DIV = 97408,
  parameter int BEEP_LEN   = 5400000,
  parameter int ACC_W      = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run,
  input  logic [7:0] bpm,
  input  logic [3:0] beats_per_bar,
  output logic [6:0] seg,
  output logic       speaker_out,
  output logic       beat_pulse,
  output logic       bar_pulse
);

  localparam logic [ACC_W-1:0] TICK_LIMIT = ACC_W'(64'(CLK_HZ) * 64'd60);
  localparam int DIV_MAX = (ACCENT_DIV > NORMAL_DIV) ? ACCENT_DIV : NORMAL_DIV;
  localparam int DIV_W   = (DIV_MAX > 2) ? $clog2(DIV_MAX) : 1;
  localparam logic [DIV_W-1:0] ACC_LAST = DIV_W'(ACCENT_DIV - 1);
  localparam logic [DIV_W-1:0] ACC_HALF = DIV_W'(ACCENT_DIV / 2);
  localparam logic [DIV_W-1:0] NOR_LAST = DIV_W'(NORMAL_DIV - 1);
  localparam logic [DIV_W-1:0] NOR_HALF = DIV_W'(NORMAL_DIV / 2);
  localparam int BEEP_W = $clog2(BEEP_LEN + 1);
  localparam logic [BEEP_W-1:0] BEEP_INIT = BEEP_W'(BEEP_LEN);
  localparam logic [3:0] BPB_MAX = 4'(BEATS_MAX);
  localparam logic [6:0] SEG_ONE = 7'b0110000;

  logic              r_run_d;
  logic [ACC_W-1:0]  r_acc;
  logic [3:0]        r_beat;
  logic [6:0]        r_seg;
  logic              r_spk;
  logic              r_beat_pulse;
  logic              r_bar_pulse;
  logic [BEEP_W-1:0] r_beep_cnt;
  logic [DIV_W-1:0]  r_div_cnt;
  logic              r_sel;

  logic              w_start;
  logic              w_tick;
  logic              w_event;
  logic [ACC_W-1:0]  w_sum;
  logic [3:0]        w_bpb_eff;
  logic [3:0]        w_new_beat;
  logic [DIV_W-1:0]  w_div_last;
  logic [DIV_W-1:0]  w_div_half;
  logic [DIV_W-1:0]  w_div_next;
  logic              w_spk_next;

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd1:    s = 7'b0110000;
      4'd2:    s = 7'b1101101;
      4'd3:    s = 7'b1111001;
      4'd4:    s = 7'b0110011;
      4'd5:    s = 7'b1011011;
      4'd6:    s = 7'b1011111;
      4'd7:    s = 7'b1110000;
      4'd8:    s = 7'b1111111;
      4'd9:    s = 7'b1111011;
      default: s = 7'b0000000;
    endcase
    return s;
  endfunction

  // acc stays below TICK_LIMIT, so acc+bpm never overflows ACC_W
  always_comb begin
    w_start = 1'b0;
    w_tick  = 1'b0;
    w_sum   = r_acc + {{(ACC_W-8){1'b0}}, bpm};
    w_start = run && !r_run_d;
    w_tick  = run && r_run_d && (w_sum >= TICK_LIMIT);
    w_event = w_start || w_tick;
  end

  always_comb begin
    w_bpb_eff  = BPB_MAX;
    w_new_beat = 4'd1;
    if ((beats_per_bar != 4'd0) && (beats_per_bar <= BPB_MAX)) begin
      w_bpb_eff = beats_per_bar;
    end
    if (!w_start && (r_beat < w_bpb_eff)) begin
      w_new_beat = r_beat + 4'd1;
    end
  end

  always_comb begin
    w_div_last = r_sel ? ACC_LAST : NOR_LAST;
    w_div_half = r_sel ? ACC_HALF : NOR_HALF;
    w_div_next = (r_div_cnt >= w_div_last) ? '0 : r_div_cnt + DIV_W'(1);
    // last beep cycle (count 1) hands over to silence on this edge
    w_spk_next = (r_beep_cnt > BEEP_W'(1)) && (w_div_next < w_div_half);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_run_d <= 1'b0;
      r_acc   <= '0;
    end else begin
      r_run_d <= run;
      if (w_start) begin
        r_acc <= '0;
      end else if (w_tick) begin
        r_acc <= w_sum - TICK_LIMIT;
      end else if (run) begin
        r_acc <= w_sum;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_beat       <= 4'd1;
      r_seg        <= SEG_ONE;
      r_beat_pulse <= 1'b0;
      r_bar_pulse  <= 1'b0;
    end else begin
      r_beat_pulse <= w_event;
      r_bar_pulse  <= w_event && (w_new_beat == 4'd1);
      if (w_event) begin
        r_beat <= w_new_beat;
        r_seg  <= seg_decode(w_new_beat);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_beep_cnt <= '0;
      r_div_cnt  <= '0;
      r_sel      <= 1'b0;
      r_spk      <= 1'b0;
    end else if (w_event) begin
      r_beep_cnt <= BEEP_INIT;
      r_div_cnt  <= '0;
      r_sel      <= (w_new_beat == 4'd1);
      r_spk      <= 1'b1;
    end else if (!run) begin
      r_beep_cnt <= '0;
      r_spk      <= 1'b0;
    end else if (r_beep_cnt != '0) begin
      r_beep_cnt <= r_beep_cnt - BEEP_W'(1);
      r_div_cnt  <= w_div_next;
      r_spk      <= w_spk_next;
    end else begin
      r_spk <= 1'b0;
    end
  end

  assign seg         = r_seg;
  assign speaker_out = r_spk;
  assign beat_pulse  = r_beat_pulse;
  assign bar_pulse   = r_bar_pulse;

endmodule

// File: tb/tb_metronome_param_seven_seg.sv
// tb/tb_metronome_param_seven_seg.sv - randomized self-checking bench against a phase/time-since-beat model
module tb_metronome_param_seven_seg;

  localparam int TL        = 6000;
  localparam int BEATS_MAX = 8;
  localparam int ACC_DIV   = 10;
  localparam int NOR_DIV   = 16;
  localparam int BEEP      = 30;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       run = 1'b0;
  logic [7:0] bpm = 8'd0;
  logic [3:0] bpb = 4'd0;
  logic [6:0] seg;
  logic       speaker_out;
  logic       beat_pulse;
  logic       bar_pulse;

  metronome_param_seven_seg #(
    .CLK_HZ(100), .BEATS_MAX(BEATS_MAX), .ACCENT_DIV(ACC_DIV),
    .NORMAL_DIV(NOR_DIV), .BEEP_LEN(BEEP), .ACC_W(32)
  ) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .bpm(bpm), .beats_per_bar(bpb),
    .seg(seg), .speaker_out(speaker_out), .beat_pulse(beat_pulse), .bar_pulse(bar_pulse)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [6:0] seg_tab [0:9];
  longint m_ph;
  int     m_beat, m_t, m_div;
  bit     m_run_d, m_tone;
  logic [6:0] e_seg;
  logic   e_spk, e_bp, e_barp;

  task automatic model_reset;
    m_ph = 0; m_beat = 1; m_run_d = 0; m_tone = 0; m_t = 0; m_div = ACC_DIV;
    e_seg = seg_tab[1]; e_spk = 0; e_bp = 0; e_barp = 0;
  endtask

  // total phase m_ph crosses a multiple of TL once per beat; tone is a function of time since the beat
  task automatic tick;
    int eff, nb;
    bit ev;
    longint old;
    eff = (bpb >= 4'd1 && int'(bpb) <= BEATS_MAX) ? int'(bpb) : BEATS_MAX;
    ev = 0; nb = m_beat;
    if (run && !m_run_d) begin
      m_ph = 0; ev = 1; nb = 1;
    end else if (run) begin
      old = m_ph;
      m_ph = m_ph + longint'(bpm);
      if (m_ph / TL != old / TL) begin
        ev = 1;
        nb = (m_beat >= eff) ? 1 : m_beat + 1;
      end
    end
    m_run_d = run;
    if (ev) begin
      m_beat = nb; m_t = 0; m_div = (nb == 1) ? ACC_DIV : NOR_DIV; m_tone = 1;
    end else if (!run) begin
      m_tone = 0;
    end else begin
      m_t++;
    end
    e_seg = seg_tab[m_beat];
    e_spk = m_tone && (m_t < BEEP) && ((m_t % m_div) < m_div / 2);
    e_bp = ev;
    e_barp = ev && (nb == 1);
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    rst_n = 0; run = 1; bpm = 8'd60; bpb = 4'd4;
    model_reset();
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++;
      if ({seg, speaker_out, beat_pulse, bar_pulse} !== {7'b0110000, 3'b000}) begin
        errors++;
        $display("FAIL reset cyc=%0d got seg=%b spk=%b bp=%b bar=%b exp seg=0110000 spk=0 bp=0 bar=0",
                 i, seg, speaker_out, beat_pulse, bar_pulse);
      end
    end
    run = 0;
    @(posedge clk); #1;
    rst_n = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({seg, speaker_out, beat_pulse, bar_pulse} !== {e_seg, e_spk, e_bp, e_barp}) begin
        errors++;
        $display("FAIL reset_idle cyc=%0d got %b/%b/%b/%b exp %b/%b/%b/%b",
                 i, seg, speaker_out, beat_pulse, bar_pulse, e_seg, e_spk, e_bp, e_barp);
      end
    end
  endtask

  task automatic test_basic;
    int nbp, nbar;
    logic exp_s;
    nbp = 0; nbar = 0;
    run = 1; bpm = 8'd60; bpb = 4'd4;
    for (int c = 0; c < 450; c++) begin
      tick();
      checks++;
      if ({seg, speaker_out, beat_pulse, bar_pulse} !== {e_seg, e_spk, e_bp, e_barp}) begin
        errors++;
        $display("FAIL basic cyc=%0d got %b/%b/%b/%b exp %b/%b/%b/%b",
                 c, seg, speaker_out, beat_pulse, bar_pulse, e_seg, e_spk, e_bp, e_barp);
      end
      if (beat_pulse) nbp++;
      if (bar_pulse) begin
        nbar++;
        checks++;
        if (c != 0 && c != 400) begin
          errors++;
          $display("FAIL basic_bar_pos got bar_pulse at cyc=%0d exp only 0 or 400", c);
        end
      end
      if (c < 130) begin
        exp_s = (c < 30) ? ((c % 10) < 5) : (c >= 100) ? (((c - 100) % 16) < 8) : 1'b0;
        checks++;
        if (speaker_out !== exp_s) begin
          errors++;
          $display("FAIL basic_tone cyc=%0d got %b exp %b", c, speaker_out, exp_s);
        end
      end
    end
    checks++;
    if (nbp != 5) begin errors++; $display("FAIL basic_beat_count got %0d exp 5", nbp); end
    checks++;
    if (nbar != 2) begin errors++; $display("FAIL basic_bar_count got %0d exp 2", nbar); end
    run = 0;
    tick();
  endtask

  task automatic test_tempo;
    int last, nbp;
    run = 1; bpm = 8'd120; bpb = 4'd4;
    for (int c = 0; c < 300; c++) begin
      tick();
      checks++;
      if (beat_pulse !== ((c % 50) == 0)) begin
        errors++;
        $display("FAIL tempo120 cyc=%0d got bp=%b exp %b", c, beat_pulse, (c % 50) == 0);
      end
    end
    run = 0; tick();
    run = 1; bpm = 8'd7; last = -1; nbp = 0;
    for (int c = 0; c < 6000; c++) begin
      tick();
      if ({seg, speaker_out, beat_pulse, bar_pulse} !== {e_seg, e_spk, e_bp, e_barp}) begin
        checks++; errors++;
        $display("FAIL tempo7 cyc=%0d got %b/%b/%b/%b exp %b/%b/%b/%b",
                 c, seg, speaker_out, beat_pulse, bar_pulse, e_seg, e_spk, e_bp, e_barp);
      end
      if (beat_pulse) begin
        nbp++;
        if (last >= 0) begin
          checks++;
          if (c - last != 857 && c - last != 858) begin
            errors++;
            $display("FAIL tempo7_spacing got %0d exp 857 or 858", c - last);
          end
        end
        last = c;
      end
    end
    checks++;
    if (nbp != 7) begin errors++; $display("FAIL tempo7_count got %0d exp 7", nbp); end
    run = 0; tick();
    run = 1; bpm = 8'd60;
    for (int c = 0; c < 160; c++) begin
      if (c == 50) bpm = 8'd120;
      tick();
      checks++;
      if (beat_pulse !== (c == 0 || c == 75 || c == 125) || beat_pulse !== e_bp) begin
        errors++;
        $display("FAIL tempo_change cyc=%0d got bp=%b exp %b", c, beat_pulse, e_bp);
      end
    end
    run = 0; tick();
  endtask

  task automatic test_bar_len;
    int kexp;
    run = 1; bpm = 8'd120; bpb = 4'd4;
    for (int c = 0; c < 161; c++) begin
      if (c == 110) bpb = 4'd2;
      tick();
      checks++;
      if ({seg, speaker_out, beat_pulse, bar_pulse} !== {e_seg, e_spk, e_bp, e_barp}) begin
        errors++;
        $display("FAIL bar_len cyc=%0d got %b/%b/%b/%b exp %b/%b/%b/%b",
                 c, seg, speaker_out, beat_pulse, bar_pulse, e_seg, e_spk, e_bp, e_barp);
      end
      if (c == 150) begin
        checks++;
        if ({seg, bar_pulse} !== {7'b0110000, 1'b1}) begin
          errors++;
          $display("FAIL bar_shrink got seg=%b bar=%b exp seg=0110000 bar=1", seg, bar_pulse);
        end
      end
    end
    kexp = 1;
    for (int c = 161; c < 1100; c++) begin
      bpb = (c < 600) ? 4'd0 : 4'd12;
      tick();
      if (beat_pulse) begin
        kexp = (kexp == 8) ? 1 : kexp + 1;
        checks++;
        if (seg !== seg_tab[kexp] || bar_pulse !== (kexp == 1)) begin
          errors++;
          $display("FAIL bar_clamp cyc=%0d got seg=%b bar=%b exp seg=%b bar=%b",
                   c, seg, bar_pulse, seg_tab[kexp], kexp == 1);
        end
      end
    end
    run = 0; tick();
  endtask

  task automatic test_stop_restart;
    run = 1; bpm = 8'd60; bpb = 4'd4;
    for (int c = 0; c < 150; c++) begin
      if (c == 110) run = 0;
      tick();
      checks++;
      if ({seg, speaker_out, beat_pulse, bar_pulse} !== {e_seg, e_spk, e_bp, e_barp}) begin
        errors++;
        $display("FAIL stop cyc=%0d got %b/%b/%b/%b exp %b/%b/%b/%b",
                 c, seg, speaker_out, beat_pulse, bar_pulse, e_seg, e_spk, e_bp, e_barp);
      end
      if (c >= 110) begin
        checks++;
        if ({seg, speaker_out, beat_pulse, bar_pulse} !== {7'b1101101, 3'b000}) begin
          errors++;
          $display("FAIL stop_hold cyc=%0d got seg=%b spk=%b bp=%b bar=%b exp seg=1101101 spk=0 bp=0 bar=0",
                   c, seg, speaker_out, beat_pulse, bar_pulse);
        end
      end
    end
    run = 1;
    for (int c = 0; c < 40; c++) begin
      tick();
      checks++;
      if (speaker_out !== (c < 30 && (c % 10) < 5) || speaker_out !== e_spk) begin
        errors++;
        $display("FAIL restart_tone cyc=%0d got %b exp %b", c, speaker_out, e_spk);
      end
      if (c == 0) begin
        checks++;
        if ({seg, beat_pulse, bar_pulse} !== {7'b0110000, 2'b11}) begin
          errors++;
          $display("FAIL restart_accent got seg=%b bp=%b bar=%b exp seg=0110000 bp=1 bar=1",
                   seg, beat_pulse, bar_pulse);
        end
      end
    end
    run = 0; tick();
  endtask

  task automatic test_random;
    int len;
    for (int s = 0; s < 14; s++) begin
      run = ($urandom_range(0, 4) != 0);
      bpm = 8'($urandom_range(0, 255));
      bpb = 4'($urandom_range(0, 15));
      len = $urandom_range(20, 300);
      for (int c = 0; c < len; c++) begin
        if ($urandom_range(0, 99) == 0) bpm = 8'($urandom_range(0, 255));
        if ($urandom_range(0, 199) == 0) bpb = 4'($urandom_range(0, 15));
        tick();
        checks++;
        if ({seg, speaker_out, beat_pulse, bar_pulse} !== {e_seg, e_spk, e_bp, e_barp}) begin
          errors++;
          $display("FAIL random seg%0d cyc=%0d bpm=%0d bpb=%0d got %b/%b/%b/%b exp %b/%b/%b/%b",
                   s, c, bpm, bpb, seg, speaker_out, beat_pulse, bar_pulse, e_seg, e_spk, e_bp, e_barp);
        end
      end
    end
    run = 0; tick();
  endtask

  task automatic test_async_reset;
    run = 1; bpm = 8'd60; bpb = 4'd4;
    for (int c = 0; c < 3; c++) tick();
    checks++;
    if (speaker_out !== 1'b1 || e_spk !== 1'b1) begin
      errors++;
      $display("FAIL async_pre got spk=%b exp 1", speaker_out);
    end
    #2;
    rst_n = 0;
    #1;
    checks++;
    if ({seg, speaker_out, beat_pulse, bar_pulse} !== {7'b0110000, 3'b000}) begin
      errors++;
      $display("FAIL async_reset got seg=%b spk=%b bp=%b bar=%b exp seg=0110000 spk=0 bp=0 bar=0",
               seg, speaker_out, beat_pulse, bar_pulse);
    end
    model_reset();
    run = 0;
    @(posedge clk); #1;
    rst_n = 1;
    run = 1;
    for (int c = 0; c < 40; c++) begin
      tick();
      checks++;
      if ({seg, speaker_out, beat_pulse, bar_pulse} !== {e_seg, e_spk, e_bp, e_barp}) begin
        errors++;
        $display("FAIL post_reset cyc=%0d got %b/%b/%b/%b exp %b/%b/%b/%b",
                 c, seg, speaker_out, beat_pulse, bar_pulse, e_seg, e_spk, e_bp, e_barp);
      end
    end
  endtask

  initial begin
    seg_tab = '{7'b0000000, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
                7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011};
    test_reset();
    test_basic();
    test_tempo();
    test_bar_len();
    test_stop_restart();
    test_random();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
